mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between the fetch (imem) and load/store (dmem) requesters.
//  One transaction in flight; dmem has priority, and imem gets a bounded anti-starvation slot.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_arb_pick.sv | 14 +
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the imem/dmem memory port arbiter: memory request
// encodings, arbiter FSM states and transaction owner tags.
package mem_port_arbiter_pkg;

  typedef enum logic {
    M_XRD = 1'b0,
    M_XWR = 1'b1
  } mem_write_signal_e;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd4,
    MT_HU = 3'd5,
    MT_WU = 3'd6
  } mem_mask_type_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } arb_state_e;

  typedef enum logic {
    OWN_I,
    OWN_D
  } arb_owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between the fetch and load/store requesters. Load/store
// normally wins; fetch wins when it is alone or when it has been starved.
module mem_arb_pick (
  input  logic i_valid,
  input  logic d_valid,
  input  logic starve_hit,
  output logic grant_i,
  output logic grant_d
);

  assign grant_i = i_valid & (starve_hit | ~d_valid);
  assign grant_d = d_valid & ~(starve_hit & i_valid);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between imem and dmem. One transaction
// is in flight at a time; the response is routed back to its owner.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic [DATA_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_fcn,
  input  logic [2:0]        d_req_typ,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  output logic [DATA_W-1:0] d_resp_data,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic              m_req_fcn,
  output logic [2:0]        m_req_typ,
  output logic [DATA_W-1:0] m_req_wdata,
  input  logic              m_resp_valid,
  input  logic [DATA_W-1:0] m_resp_data,
  output logic              err_spurious
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e       state;
  arb_owner_e       owner;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;
  logic             grant_i;
  logic             grant_d;
  logic             idle;

  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  mem_arb_pick u_pick (
    .i_valid    (i_req_valid),
    .d_valid    (d_req_valid),
    .starve_hit (starve_hit),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Readies are only offered in IDLE, and never while reset is asserted.
  assign idle        = (state == ARB_IDLE) & reset;
  assign i_req_ready = idle & grant_i;
  assign d_req_ready = idle & grant_d;

  // Arbiter FSM with registered memory request, responses and starve counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ARB_IDLE;
      owner        <= OWN_I;
      starve_cnt   <= '0;
      err_spurious <= 1'b0;
      m_req_valid  <= 1'b0;
      m_req_addr   <= '0;
      m_req_fcn    <= 1'b0;
      m_req_typ    <= '0;
      m_req_wdata  <= '0;
      i_resp_valid <= 1'b0;
      i_resp_data  <= '0;
      d_resp_valid <= 1'b0;
      d_resp_data  <= '0;
    end else begin
      i_resp_valid <= 1'b0;
      d_resp_valid <= 1'b0;
      if (m_resp_valid && (state != ARB_WAIT)) begin
        err_spurious <= 1'b1;
      end
      case (state)
        ARB_IDLE: begin
          if (!i_req_valid || grant_i) begin
            starve_cnt <= '0;
          end else if (grant_d && !starve_hit) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
          end
          if (grant_d) begin
            owner       <= OWN_D;
            m_req_addr  <= d_req_addr;
            m_req_fcn   <= d_req_fcn;
            m_req_typ   <= d_req_typ;
            m_req_wdata <= d_req_wdata;
            m_req_valid <= 1'b1;
            state       <= ARB_ISSUE;
          end else if (grant_i) begin
            owner       <= OWN_I;
            m_req_addr  <= i_req_addr;
            m_req_fcn   <= M_XRD;
            m_req_typ   <= MT_WU;
            m_req_wdata <= '0;
            m_req_valid <= 1'b1;
            state       <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (m_req_ready) begin
            m_req_valid <= 1'b0;
            state       <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (m_resp_valid) begin
            if (owner == OWN_I) begin
              i_resp_data  <= m_resp_data;
              i_resp_valid <= 1'b1;
            end else begin
              d_resp_data  <= m_resp_data;
              d_resp_valid <= 1'b1;
            end
            state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// request streams, checked against a transaction-level reference model.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready, i_resp_valid;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_resp_data;
  logic          d_req_valid, d_req_ready, d_req_fcn, d_resp_valid;
  logic [AW-1:0] d_req_addr;
  logic [2:0]    d_req_typ;
  logic [DW-1:0] d_req_wdata, d_resp_data;
  logic          m_req_valid, m_req_ready, m_req_fcn, m_resp_valid;
  logic [AW-1:0] m_req_addr;
  logic [2:0]    m_req_typ;
  logic [DW-1:0] m_req_wdata, m_resp_data;
  logic          err_spurious;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_fcn(d_req_fcn), .d_req_typ(d_req_typ), .d_req_wdata(d_req_wdata),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ), .m_req_wdata(m_req_wdata),
    .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
    .err_spurious(err_spurious)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  // ---------------- memory environment ----------------
  logic [31:0] ram [logic [31:0]];
  int rdy_delay = 0, resp_delay = 2;
  int spur_req = 0, spur_done = 0;
  int acc_cnt = 0;
  bit mbusy = 0, mseen = 0;
  int rdy_wait = 0, mcnt = 0;
  logic [31:0] mpend;

  initial begin : mem_proc
    m_req_ready = 1'b0; m_resp_valid = 1'b0; m_resp_data = '0;
    forever begin
      @(negedge clk);
      if (reset && m_req_valid && m_req_ready && !mbusy) begin
        mbusy = 1; mseen = 0; acc_cnt++;
        if (m_req_fcn == M_XWR) begin
          ram[m_req_addr] = m_req_wdata;
          mpend = ~m_req_wdata;
        end else begin
          mpend = ram.exists(m_req_addr) ? ram[m_req_addr] : dflt(m_req_addr);
        end
        mcnt = (resp_delay < 0) ? int'($urandom_range(1, 3)) : resp_delay;
      end
      @(posedge clk); #1;
      m_resp_valid = 1'b0;
      if (!reset) begin
        mbusy = 0; mseen = 0; m_req_ready = 1'b0;
      end else if (spur_done != spur_req) begin
        spur_done++;
        m_resp_valid = 1'b1; m_resp_data = 32'h5A5A_5A5A;
      end else if (mbusy) begin
        m_req_ready = 1'b0;
        mcnt--;
        if (mcnt == 0) begin
          m_resp_valid = 1'b1; m_resp_data = mpend; mbusy = 0;
        end
      end else if (m_req_valid) begin
        if (!mseen) begin
          mseen = 1;
          rdy_wait = (rdy_delay < 0) ? int'($urandom_range(0, 3)) : rdy_delay;
        end
        if (rdy_wait > 0) begin rdy_wait--; m_req_ready = 1'b0; end
        else m_req_ready = 1'b1;
      end else begin
        m_req_ready = 1'b0;
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [31:0] refm [logic [31:0]];
  int          i_left, d_left, scnt, exp_lat;
  bit          force_lw;
  string       glog;
  bit          pend, pend_own_i, pend_wr, have_i;
  logic [31:0] pend_addr, pend_data, pend_wdata, last_i_exp;
  logic        pend_fcn;
  logic [2:0]  pend_typ;

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : dflt(a);
  endfunction

  task automatic new_i();
    i_req_valid = (i_left > 0);
    i_req_addr  = (i_left > 0) ? (32'($urandom_range(0, 15)) << 2) : $urandom;
  endtask

  task automatic new_d();
    d_req_valid = (d_left > 0);
    if (force_lw) begin
      d_req_addr = 32'h100; d_req_fcn = M_XRD; d_req_typ = MT_W; d_req_wdata = $urandom;
    end else if (d_left > 0) begin
      d_req_addr  = 32'($urandom_range(0, 15)) << 2;
      d_req_fcn   = 1'($urandom_range(0, 1));
      d_req_typ   = 3'($urandom_range(0, 6));
      d_req_wdata = $urandom;
    end else begin
      d_req_addr = $urandom; d_req_fcn = 1'($urandom_range(0, 1)); d_req_wdata = $urandom;
    end
  endtask

  task automatic run(input int ni, input int nd, input string tag);
    int cyc, gcyc;
    bit wi, wd, ew_i, ew_d;
    i_left = ni; d_left = nd; pend = 0; scnt = 0; glog = ""; gcyc = 0;
    repeat (2) @(posedge clk);
    #1; new_i(); new_d();
    cyc = 0;
    while ((i_left > 0 || d_left > 0 || pend) && cyc < 600) begin
      @(negedge clk); cyc++;
      wi = 0; wd = 0;
      if (i_resp_valid || d_resp_valid) begin
        check({tag, " resp owner"}, {i_resp_valid, d_resp_valid},
              pend ? (pend_own_i ? 2'b10 : 2'b01) : 2'b00);
        if (pend) begin
          check({tag, " mem fields"}, {m_req_addr, m_req_fcn, m_req_typ},
                {pend_addr, pend_fcn, pend_typ});
          if (pend_wr) check({tag, " mem wdata"}, m_req_wdata, pend_wdata);
          if (pend_own_i) begin
            check({tag, " i data"}, i_resp_data, pend_data);
            last_i_exp = pend_data; have_i = 1;
          end else if (!pend_wr) begin
            check({tag, " d data"}, d_resp_data, pend_data);
          end
          if (exp_lat > 0) check({tag, " latency"}, cyc - gcyc, exp_lat);
        end
        pend = 0;
      end
      if (pend && m_req_valid && !m_req_ready)
        check({tag, " req stable"}, {m_req_addr, m_req_fcn, m_req_typ},
              {pend_addr, pend_fcn, pend_typ});
      if (i_req_ready || d_req_ready) begin
        ew_i = i_req_valid && (scnt == LIM || !d_req_valid);
        ew_d = d_req_valid && !ew_i;
        check({tag, " grant"}, {i_req_ready, d_req_ready}, pend ? 2'b00 : {ew_i, ew_d});
        wi = i_req_valid && i_req_ready;
        wd = d_req_valid && d_req_ready && !wi;
        gcyc = cyc;
        if (wi) begin
          scnt = 0; pend = 1; pend_own_i = 1; pend_wr = 0;
          pend_addr = i_req_addr; pend_fcn = M_XRD; pend_typ = MT_WU;
          pend_data = model_rd(i_req_addr);
          i_left--; glog = {glog, "I"};
        end else if (wd) begin
          scnt = !i_req_valid ? 0 : (scnt < LIM ? scnt + 1 : scnt);
          pend = 1; pend_own_i = 0; pend_wr = (d_req_fcn == M_XWR);
          pend_addr = d_req_addr; pend_fcn = d_req_fcn; pend_typ = d_req_typ;
          pend_wdata = d_req_wdata;
          pend_data = model_rd(d_req_addr);
          if (pend_wr) refm[d_req_addr] = d_req_wdata;
          d_left--; glog = {glog, "D"};
        end
      end
      @(posedge clk); #1;
      if (wi) new_i();
      if (wd) new_d();
    end
    if (cyc >= 600) check({tag, " timeout"}, 1, 0);
  endtask

  initial begin : main
    int k;
    ram[32'h100] = 32'hDEAD_BEEF;
    refm[32'h100] = 32'hDEAD_BEEF;
    reset = 1'b0; i_req_valid = 0; d_req_valid = 0;
    i_req_addr = '0; d_req_addr = '0; d_req_fcn = 0; d_req_typ = '0; d_req_wdata = '0;
    force_lw = 0; exp_lat = 0; have_i = 0; last_i_exp = '0;
    repeat (3) @(negedge clk);
    i_req_valid = 1; d_req_valid = 1;
    #2;
    check("reset readies", {i_req_ready, d_req_ready}, 2'b00);
    check("reset valids", {m_req_valid, i_resp_valid, d_resp_valid, err_spurious}, 4'b0000);
    check("reset data", {m_req_addr, i_resp_data}, 64'h0);
    check("reset d data", {m_req_wdata, d_resp_data}, 64'h0);
    i_req_valid = 0; d_req_valid = 0;
    @(negedge clk); reset = 1'b1;

    // dmem LW 0x100 alone, ready at once, response two cycles later
    rdy_delay = 0; resp_delay = 2; exp_lat = 4; force_lw = 1;
    run(0, 1, "lw");
    force_lw = 0;
    check("lw data held", d_resp_data, 32'hDEAD_BEEF);

    // simultaneous requests: dmem first, then imem
    run(1, 1, "both");
    n_chk++;
    assert (glog == "DI") n_pass++;
    else begin n_fail++; $error("FAIL both order: observed %s expected DI", glog); end

    // dmem streaming with imem waiting
    resp_delay = 1; exp_lat = 3;
    run(2, 8, "starve");
    n_chk++;
    assert (glog == "DDDDIDDDDI") n_pass++;
    else begin n_fail++; $error("FAIL starve order: observed %s expected DDDDIDDDDI", glog); end

    // memory holds off for five cycles
    rdy_delay = 5; resp_delay = 2; exp_lat = 9;
    run(0, 1, "stall");
    run(1, 0, "stall_i");

    // random streams with random memory timing
    rdy_delay = -1; resp_delay = -1; exp_lat = 0;
    for (k = 0; k < 12; k++) run(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), "rand");
    if (have_i) check("i data held", i_resp_data, last_i_exp);

    // spurious memory response while idle
    rdy_delay = 0; resp_delay = 2;
    @(posedge clk); #1; spur_req++;
    repeat (4) begin
      @(negedge clk);
      check("spur no strobe", {i_resp_valid, d_resp_valid}, 2'b00);
    end
    check("spur flag", err_spurious, 1'b1);
    run(1, 0, "after_spur");
    check("spur sticky", err_spurious, 1'b1);

    // reset while a transaction waits on memory
    resp_delay = 8;
    @(posedge clk); #1;
    d_req_valid = 1; d_req_addr = 32'h40; d_req_fcn = M_XRD; d_req_typ = MT_W;
    k = 0;
    do begin @(negedge clk); k++; end while (!d_req_ready && k < 20);
    @(posedge clk); #1; d_req_valid = 0;
    k = acc_cnt;
    repeat (3) @(negedge clk);
    check("rst_wait accepted", acc_cnt - k, 1);
    reset = 1'b0; i_req_valid = 1; d_req_valid = 1;
    #2;
    check("rst_wait readies", {i_req_ready, d_req_ready}, 2'b00);
    check("rst_wait valids", {m_req_valid, i_resp_valid, d_resp_valid, err_spurious}, 4'b0000);
    @(negedge clk);
    reset = 1'b1; i_req_valid = 0; d_req_valid = 0;
    repeat (12) begin
      @(negedge clk);
      check("rst_wait quiet", {m_req_valid, i_resp_valid, d_resp_valid, err_spurious}, 4'b0000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
